inst_encoder: RTL and testbench

Streaming RV32I instruction encoder: the inverse of the immediate generator. It accepts decoded instruction fields and a full 32-bit immediate, range-checks the immediate for the selected format, and packs everything into a 32-bit instruction word. Each word is tagged with a sequential write address. It sits between the test/program-loader front end and instruction memory, and uses a valid/ready handshake on both sides with a single registered output stage.

---
 rtl/inst_encoder_if.sv | 42 ++++
 rtl/inst_encoder.sv | 137 +++++++++++++
 tb/tb_inst_encoder.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder_if
//  Description : Field-input and instruction-output handshake bundle for the
//                RV32I instruction encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_encoder_if #(
    parameter int ADDR_W = 8
) ();
    // Producer side: decoded fields
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    // Consumer side: encoded words
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [15:0]       err_count;

    // Encoder end of the bundle
    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );

    // Loader / memory end of the bundle
    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_err, err_count
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : inst_encoder
//  Description : Streaming RV32I instruction encoder. Range-checks the
//                immediate for the selected format, packs the fields into a
//                32-bit word (NOP on illegal encodings) and tags each word
//                with a sequential write address. One registered output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder #(
    parameter int ADDR_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    inst_encoder_if.slave      bus
);

    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [15:0] c_ERR_MAX  = 16'hFFFF;

    localparam logic [2:0]  c_FMT_R    = 3'd0;
    localparam logic [2:0]  c_FMT_I    = 3'd1;
    localparam logic [2:0]  c_FMT_S    = 3'd2;
    localparam logic [2:0]  c_FMT_B    = 3'd3;
    localparam logic [2:0]  c_FMT_U    = 3'd4;
    localparam logic [2:0]  c_FMT_J    = 3'd5;

    localparam logic [0:0]  c_EMPTY    = 1'b0;
    localparam logic [0:0]  c_FULL     = 1'b1;

    logic [0:0]        r_state;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_err;
    logic [15:0]       r_err_count;
    logic [ADDR_W-1:0] r_addr_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic [31:0]       w_packed;
    logic              w_illegal;
    logic [31:0]       w_inst;
    logic              w_sx_11;
    logic              w_sx_12;
    logic              w_sx_20;

    // Upper immediate bits must be pure sign extension of the encodable field
    assign w_sx_11 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
    assign w_sx_12 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
    assign w_sx_20 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

    // Ready depends only on the output register and the consumer, never on in_valid
    assign w_in_ready = (r_state == c_EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Format-specific bit packing and legality check
    always_comb begin
        w_packed  = 32'd0;
        w_illegal = 1'b0;
        case (bus.fmt)
            c_FMT_R: begin
                w_packed = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            c_FMT_I: begin
                w_packed  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                w_illegal = ~w_sx_11;
            end
            c_FMT_S: begin
                w_packed  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:0], bus.opcode};
                w_illegal = ~w_sx_11;
            end
            c_FMT_B: begin
                w_packed  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                             bus.imm[4:1], bus.imm[11], bus.opcode};
                w_illegal = ~w_sx_12 | bus.imm[0];
            end
            c_FMT_U: begin
                w_packed  = {bus.imm[31:12], bus.rd, bus.opcode};
                w_illegal = |bus.imm[11:0];
            end
            c_FMT_J: begin
                w_packed  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                             bus.rd, bus.opcode};
                w_illegal = ~w_sx_20 | bus.imm[0];
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_inst = w_illegal ? c_NOP : w_packed;

    // Output register FSM: capture on accept, drain when consumer takes the word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_EMPTY;
            r_out_inst  <= 32'd0;
            r_out_addr  <= '0;
            r_out_err   <= 1'b0;
            r_err_count <= 16'd0;
            r_addr_cnt  <= '0;
        end else begin
            case (r_state)
                c_EMPTY: begin
                    if (w_accept) begin
                        r_state <= c_FULL;
                    end
                end
                default: begin
                    if (bus.out_ready && !w_accept) begin
                        r_state <= c_EMPTY;
                    end
                end
            endcase
            if (w_accept) begin
                r_out_inst <= w_inst;
                r_out_addr <= r_addr_cnt;
                r_out_err  <= w_illegal;
                r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
                if (w_illegal && (r_err_count != c_ERR_MAX)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == c_FULL);
    assign bus.out_inst  = r_out_inst;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_err   = r_out_err;
    assign bus.err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_encoder
//  Description : Self-checking bench for inst_encoder: directed encodings,
//                illegal immediates, backpressure, reset while stalled,
//                address wrap, error-count saturation and random traffic
//                compared against a behavioural model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

    localparam int ADDR_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_valid  = 1'b0;
    logic [31:0] m_inst   = 32'd0;
    int          m_addr   = 0;
    bit          m_err    = 1'b0;
    int          m_cnt    = 0;
    int          m_errcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Encoding straight from the format table; legality as signed ranges
    function automatic void model_enc(input logic [2:0] f, input logic [6:0] op,
                                      input logic [4:0] rd_i, input logic [4:0] rs1_i,
                                      input logic [4:0] rs2_i, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] im,
                                      output logic [31:0] inst, output bit err);
        int s;
        s    = im;
        err  = 1'b0;
        inst = 32'h13;
        case (f)
            3'd0: inst = {f7, rs2_i, rs1_i, f3, rd_i, op};
            3'd1: begin
                err  = (s < -2048) || (s > 2047);
                inst = {im[11:0], rs1_i, f3, rd_i, op};
            end
            3'd2: begin
                err  = (s < -2048) || (s > 2047);
                inst = {im[11:5], rs2_i, rs1_i, f3, im[4:0], op};
            end
            3'd3: begin
                err  = (s < -4096) || (s > 4095) || (im % 2 != 0);
                inst = {im[12], im[10:5], rs2_i, rs1_i, f3, im[4:1], im[11], op};
            end
            3'd4: begin
                err  = (im % 4096) != 0;
                inst = {im[31:12], rd_i, op};
            end
            3'd5: begin
                err  = (s < -1048576) || (s > 1048575) || (im % 2 != 0);
                inst = {im[20], im[10:1], im[11], im[19:12], rd_i, op};
            end
            default: err = 1'b1;
        endcase
        if (err) inst = 32'h13;
    endfunction

    // Model advances on each rising edge from the same inputs the DUT sees
    always @(posedge clk) begin
        logic [31:0] e_inst;
        bit          e_err;
        bit          e_ready;
        if (rst) begin
            m_valid = 1'b0; m_inst = 32'd0; m_addr = 0; m_err = 1'b0;
            m_cnt = 0; m_errcnt = 0;
        end else begin
            e_ready = !m_valid || bus.out_ready;
            if (bus.in_valid && e_ready) begin
                model_enc(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                          bus.funct3, bus.funct7, bus.imm, e_inst, e_err);
                m_valid = 1'b1;
                m_inst  = e_inst;
                m_err   = e_err;
                m_addr  = m_cnt;
                m_cnt   = (m_cnt + 1) % (1 << ADDR_W);
                if (e_err && m_errcnt < 65535) m_errcnt++;
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Per-cycle comparison, after the falling edge when everything has settled
    always begin
        @(negedge clk);
        #2;
        chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, (!m_valid || bus.out_ready)});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
        chk("err_count", {16'd0, bus.err_count}, m_errcnt);
        if (m_valid) begin
            chk("out_inst", bus.out_inst, m_inst);
            chk("out_addr", {30'd0, bus.out_addr}, m_addr);
            chk("out_err",  {31'd0, bus.out_err}, {31'd0, m_err});
        end
    end

    task automatic beat(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_i,
                        input logic [4:0] rs1_i, input logic [4:0] rs2_i,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        bus.fmt = f; bus.opcode = op; bus.rd = rd_i; bus.rs1 = rs1_i; bus.rs2 = rs2_i;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = im; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_out(input string name, input logic [31:0] inst,
                              input int addr, input bit err);
        chk({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({name, "_inst"},  bus.out_inst, inst);
        chk({name, "_addr"},  {30'd0, bus.out_addr}, addr);
        chk({name, "_err"},   {31'd0, bus.out_err}, {31'd0, err});
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_imm();
        int picks [12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                           1048574, 1048576, -1048576, -1048578};
        int v;
        case ($urandom_range(0, 4))
            0: return $urandom;
            1: begin v = int'($urandom_range(0, 8191)) - 4096; return v; end
            2: begin v = int'($urandom_range(0, 4194303)) - 2097152; return v & ~1; end
            3: return $urandom & 32'hFFFF_F000;
            default: return picks[$urandom_range(0, 11)];
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.fmt = 3'd0; bus.opcode = 7'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
        bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_inst",  bus.out_inst, 32'd0);
        chk("rst_out_addr",  {30'd0, bus.out_addr}, 32'd0);
        chk("rst_out_err",   {31'd0, bus.out_err}, 32'd0);
        chk("rst_err_count", {16'd0, bus.err_count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);

        // addi x1,x0,-1
        bus.out_ready = 1'b1;
        beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        bus.in_valid = 1'b0;
        expect_out("addi", 32'hFFF0_0093, 0, 1'b0);

        // beq / jal / lui back to back, then illegal words (address wraps at 4)
        do_reset();
        beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        expect_out("beq", 32'h0020_8463, 0, 1'b0);
        beat(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        expect_out("jal", 32'h0010_00EF, 1, 1'b0);
        beat(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        expect_out("lui", 32'h1234_52B7, 2, 1'b0);
        beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        expect_out("i_2048", 32'h13, 3, 1'b1);
        chk("i_2048_errcnt", {16'd0, bus.err_count}, 32'd1);
        beat(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        expect_out("b_odd", 32'h13, 0, 1'b1);
        chk("b_odd_errcnt", {16'd0, bus.err_count}, 32'd2);
        beat(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'd0, 32'd0);
        expect_out("fmt7", 32'h13, 1, 1'b1);
        chk("fmt7_errcnt", {16'd0, bus.err_count}, 32'd3);
        bus.in_valid = 1'b0;

        // Backpressure: first beat captured, second waits while outputs hold
        do_reset();
        bus.out_ready = 1'b0;
        beat(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
        beat(3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd0, 7'd0, 32'd5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        expect_out("bp_hold", 32'h4031_00B3, 0, 1'b0);
        chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        expect_out("bp_second", 32'h0054_0393, 1, 1'b0);

        // Reset while full and stalled, with a beat presented in the reset cycle
        bus.out_ready = 1'b0;
        beat(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rs_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rs_out_inst",  bus.out_inst, 32'd0);
        chk("rs_err_count", {16'd0, bus.err_count}, 32'd0);
        chk("rs_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        beat(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
        bus.in_valid = 1'b0;
        expect_out("rs_next", 32'hABCD_E117, 0, 1'b0);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bus.fmt    = 3'($urandom_range(0, 7));
            bus.opcode = 7'($urandom);
            bus.rd     = 5'($urandom);
            bus.rs1    = 5'($urandom);
            bus.rs2    = 5'($urandom);
            bus.funct3 = 3'($urandom);
            bus.funct7 = 7'($urandom);
            bus.imm    = rand_imm();
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            @(negedge clk);
        end

        // Error counter saturation
        do_reset();
        bus.out_ready = 1'b1;
        bus.fmt = 3'd6;
        bus.in_valid = 1'b1;
        repeat (65537) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("sat_err_count", {16'd0, bus.err_count}, 32'h0000_FFFF);
        @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
